serial_adder: RTL and testbench



---
 rtl/serial_adder_pkg.sv | 20 ++
 rtl/halfadder.sv | 12 +
 rtl/serial_adder_fa_slice.sv | 30 +++
 rtl/serial_adder.sv | 132 +++++++++++++
 tb/tb_serial_adder.sv | 259 +++++++++++++++++++++++++
 5 files changed

// File: rtl/serial_adder_pkg.sv
// Shared types and constants for the bit-serial adder: FSM state encodings
// and the counter width helper.
package serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam logic [1:0] ST_IDLE = IDLE;
    localparam logic [1:0] ST_RUN  = RUN;
    localparam logic [1:0] ST_DONE = DONE;

    // Counter must hold values 0..width inclusive.
    function automatic int cnt_w(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/halfadder.sv
// Single-bit half adder cell: sum is the XOR, extra is the carry (AND).
module halfadder (
    input  logic a_i,
    input  logic b_i,
    output logic sum_o,
    output logic extra_o
);

    assign sum_o   = a_i ^ b_i;
    assign extra_o = a_i & b_i;

endmodule

// File: rtl/serial_adder_fa_slice.sv
// Full-adder bit slice built from two halfadder cells and an OR of their carries.
module fa_slice (
    input  logic a_i,
    input  logic b_i,
    input  logic c_i,
    output logic s_o,
    output logic c_o
);

    logic s1_s;
    logic c1_s;
    logic c2_s;

    halfadder u_ha0 (
        .a_i     (a_i),
        .b_i     (b_i),
        .sum_o   (s1_s),
        .extra_o (c1_s)
    );

    halfadder u_ha1 (
        .a_i     (s1_s),
        .b_i     (c_i),
        .sum_o   (s_o),
        .extra_o (c2_s)
    );

    assign c_o = c1_s | c2_s;

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder, LSB first, one bit per clock.
// Optional subtract mode (a-b, carry_out=1 means no borrow) under SERIAL_ADDER_SUB_EN.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry_out
);

    localparam int              CNT_W    = cnt_w(WIDTH);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    logic [1:0]       state_q,     state_d;
    logic [WIDTH-1:0] a_sh_q,      a_sh_d;
    logic [WIDTH-1:0] b_sh_q,      b_sh_d;
    logic [WIDTH-1:0] result_q,    result_d;
    logic [CNT_W-1:0] cnt_q,       cnt_d;
    logic             carry_q,     carry_d;
    logic             carry_out_q, carry_out_d;
    logic             busy_q,      busy_d;
    logic             done_q,      done_d;

    logic             sub_s;
    logic             slice_sum_s;
    logic             slice_carry_s;

`ifdef SERIAL_ADDER_SUB_EN
    assign sub_s = sub;
`else
    assign sub_s = 1'b0;
`endif

    fa_slice u_fa_slice (
        .a_i (a_sh_q[0]),
        .b_i (b_sh_q[0]),
        .c_i (carry_q),
        .s_o (slice_sum_s),
        .c_o (slice_carry_s)
    );

    // Next-state logic: load on an accepted start, shift one bit per RUN edge.
    always_comb begin
        state_d     = state_q;
        a_sh_d      = a_sh_q;
        b_sh_d      = b_sh_q;
        result_d    = result_q;
        cnt_d       = cnt_q;
        carry_d     = carry_q;
        carry_out_d = carry_out_q;
        busy_d      = busy_q;
        done_d      = done_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    // Subtraction is a + ~b + 1.
                    a_sh_d  = a;
                    b_sh_d  = sub_s ? ~b : b;
                    carry_d = sub_s;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    done_d  = 1'b0;
                    state_d = ST_RUN;
                end else begin
                    state_d = state_q;
                end
            end
            ST_RUN: begin
                a_sh_d   = a_sh_q >> 1;
                b_sh_d   = b_sh_q >> 1;
                result_d = (result_q >> 1) | (WIDTH'(slice_sum_s) << (WIDTH - 1));
                carry_d  = slice_carry_s;
                cnt_d    = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_CNT) begin
                    carry_out_d = slice_carry_s;
                    busy_d      = 1'b0;
                    done_d      = 1'b1;
                    state_d     = ST_DONE;
                end else begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                busy_d  = 1'b0;
                done_d  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            a_sh_q      <= '0;
            b_sh_q      <= '0;
            result_q    <= '0;
            cnt_q       <= '0;
            carry_q     <= 1'b0;
            carry_out_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_sh_q      <= a_sh_d;
            b_sh_q      <= b_sh_d;
            result_q    <= result_d;
            cnt_q       <= cnt_d;
            carry_q     <= carry_d;
            carry_out_q <= carry_out_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign result    = result_q;
    assign carry_out = carry_out_q;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder (WIDTH=8), directed plus randomized
// operations against an arithmetic reference model.
module tb_serial_adder;

    localparam int WIDTH = 8;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             sub_v;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             carry_out;

    int chk_cnt;
    int pass_cnt;

    serial_adder #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .a         (a),
        .b         (b),
`ifdef SERIAL_ADDER_SUB_EN
        .sub       (sub_v),
`endif
        .busy      (busy),
        .done      (done),
        .result    (result),
        .carry_out (carry_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: {carry_out, result} from plain integer arithmetic.
    function automatic logic [WIDTH:0] ref_op(input logic [WIDTH-1:0] x,
                                               input logic [WIDTH-1:0] y,
                                               input logic s);
        longint unsigned xv, yv, m, r;
        logic co;
        xv = x;
        yv = y;
        m  = 64'd1 << WIDTH;
        if (s) begin
            co = (xv >= yv);
            r  = (xv + m - yv) % m;
        end else begin
            co = ((xv + yv) >= m);
            r  = (xv + yv) % m;
        end
        return {co, r[WIDTH-1:0]};
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b0;
        a     = '0;
        b     = '0;
        sub_v = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk_cnt++;
        if ({busy, done, result, carry_out} !== '0) begin
            $display("FAIL reset_outputs: got busy=%b done=%b result=%h co=%b, want all 0",
                     busy, done, result, carry_out);
        end else pass_cnt++;
        rst_n = 1'b1;
        @(negedge clk);
        chk_cnt++;
        if ({busy, done, result, carry_out} !== '0) begin
            $display("FAIL post_reset_idle: got busy=%b done=%b result=%h co=%b, want all 0",
                     busy, done, result, carry_out);
        end else pass_cnt++;
    endtask

    task automatic test_add_directed();
        logic [WIDTH-1:0] va [5] = '{8'h00, 8'h0F, 8'hA5, 8'hFF, 8'hFF};
        logic [WIDTH-1:0] vb [5] = '{8'h00, 8'h01, 8'h5A, 8'h01, 8'hFF};
        logic [WIDTH-1:0] vr [5] = '{8'h00, 8'h10, 8'hFF, 8'h00, 8'hFE};
        logic             vc [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        logic lat_ok;
        for (int i = 0; i < 5; i++) begin
            a = va[i]; b = vb[i]; sub_v = 1'b0; start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            lat_ok = 1'b1;
            for (int k = 0; k < WIDTH; k++) begin
                if (busy !== 1'b1 || done !== 1'b0) lat_ok = 1'b0;
                @(negedge clk);
            end
            chk_cnt++;
            if (!lat_ok || done !== 1'b1 || busy !== 1'b0) begin
                $display("FAIL dir_latency[%0d]: busy-window ok=%b done=%b busy=%b, want ok=1 done=1 busy=0",
                         i, lat_ok, done, busy);
            end else pass_cnt++;
            chk_cnt++;
            if (result !== vr[i] || carry_out !== vc[i]) begin
                $display("FAIL dir_sum[%0d]: %h+%h got %h co=%b, want %h co=%b",
                         i, va[i], vb[i], result, carry_out, vr[i], vc[i]);
            end else pass_cnt++;
        end
    endtask

    task automatic test_start_ignored();
        logic lat_ok;
        a = 8'h01; b = 8'h02; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat_ok = 1'b1;
        for (int k = 0; k < WIDTH; k++) begin
            if (busy !== 1'b1 || done !== 1'b0) lat_ok = 1'b0;
            if (k == 2) begin
                a = 8'h33; start = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        start = 1'b0;
        chk_cnt++;
        if (!lat_ok || done !== 1'b1) begin
            $display("FAIL ignore_timing: busy-window ok=%b done=%b, want ok=1 done=1", lat_ok, done);
        end else pass_cnt++;
        chk_cnt++;
        if (result !== 8'h03 || carry_out !== 1'b0) begin
            $display("FAIL ignore_sum: got %h co=%b, want 03 co=0", result, carry_out);
        end else pass_cnt++;
    endtask

    task automatic test_reset_mid_run();
        logic lat_ok;
        a = 8'h55; b = 8'h22; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk_cnt++;
        if ({busy, done, result, carry_out} !== '0) begin
            $display("FAIL midrun_reset: got busy=%b done=%b result=%h co=%b, want all 0",
                     busy, done, result, carry_out);
        end else pass_cnt++;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        a = 8'h10; b = 8'h20; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat_ok = 1'b1;
        for (int k = 0; k < WIDTH; k++) begin
            if (busy !== 1'b1 || done !== 1'b0) lat_ok = 1'b0;
            @(negedge clk);
        end
        chk_cnt++;
        if (!lat_ok || done !== 1'b1 || result !== 8'h30 || carry_out !== 1'b0) begin
            $display("FAIL after_reset_op: ok=%b done=%b got %h co=%b, want ok=1 done=1 30 co=0",
                     lat_ok, done, result, carry_out);
        end else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        logic lat_ok;
        a = 8'h12; b = 8'h34; start = 1'b1;
        @(negedge clk);
        repeat (WIDTH) @(negedge clk);
        chk_cnt++;
        if (done !== 1'b1 || result !== 8'h46 || carry_out !== 1'b0) begin
            $display("FAIL b2b_first: done=%b got %h co=%b, want done=1 46 co=0", done, result, carry_out);
        end else pass_cnt++;
        a = 8'hC8; b = 8'h64;
        @(negedge clk);
        start = 1'b0;
        chk_cnt++;
        if (done !== 1'b0 || busy !== 1'b1) begin
            $display("FAIL b2b_one_cycle_done: done=%b busy=%b, want done=0 busy=1", done, busy);
        end else pass_cnt++;
        lat_ok = 1'b1;
        for (int k = 0; k < WIDTH; k++) begin
            if (busy !== 1'b1 || done !== 1'b0) lat_ok = 1'b0;
            @(negedge clk);
        end
        chk_cnt++;
        if (!lat_ok || done !== 1'b1 || result !== 8'h2C || carry_out !== 1'b1) begin
            $display("FAIL b2b_second: ok=%b done=%b got %h co=%b, want ok=1 done=1 2c co=1",
                     lat_ok, done, result, carry_out);
        end else pass_cnt++;
    endtask

    task automatic test_sub_directed();
`ifdef SERIAL_ADDER_SUB_EN
        logic [WIDTH-1:0] va [2] = '{8'h05, 8'h03};
        logic [WIDTH-1:0] vb [2] = '{8'h03, 8'h05};
        logic [WIDTH-1:0] vr [2] = '{8'h02, 8'hFE};
        logic             vc [2] = '{1'b1, 1'b0};
        for (int i = 0; i < 2; i++) begin
            a = va[i]; b = vb[i]; sub_v = 1'b1; start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            repeat (WIDTH) @(negedge clk);
            chk_cnt++;
            if (done !== 1'b1 || result !== vr[i] || carry_out !== vc[i]) begin
                $display("FAIL sub_dir[%0d]: %h-%h done=%b got %h co=%b, want done=1 %h co=%b",
                         i, va[i], vb[i], done, result, carry_out, vr[i], vc[i]);
            end else pass_cnt++;
        end
        sub_v = 1'b0;
`endif
    endtask

    task automatic test_random();
        logic [WIDTH:0] exp_v;
        logic lat_ok;
        for (int i = 0; i < 30; i++) begin
            a = WIDTH'($urandom);
            b = WIDTH'($urandom);
`ifdef SERIAL_ADDER_SUB_EN
            sub_v = 1'($urandom_range(1, 0));
`else
            sub_v = 1'b0;
`endif
            exp_v = ref_op(a, b, sub_v);
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            a = WIDTH'($urandom);
            b = WIDTH'($urandom);
            lat_ok = 1'b1;
            for (int k = 0; k < WIDTH; k++) begin
                if (busy !== 1'b1 || done !== 1'b0) lat_ok = 1'b0;
                @(negedge clk);
            end
            chk_cnt++;
            if (!lat_ok || done !== 1'b1 || {carry_out, result} !== exp_v) begin
                $display("FAIL rand[%0d]: sub=%b ok=%b done=%b got co=%b %h, want co=%b %h",
                         i, sub_v, lat_ok, done, carry_out, result, exp_v[WIDTH], exp_v[WIDTH-1:0]);
            end else pass_cnt++;
        end
        sub_v = 1'b0;
    endtask

    initial begin
        chk_cnt  = 0;
        pass_cnt = 0;
        test_reset();
        test_add_directed();
        test_start_ignored();
        test_reset_mid_run();
        test_back_to_back();
        test_sub_directed();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
